// File: rtl/enc_rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index and valid.
// Optional hold-time preemption is enabled by defining ARB_TIMEOUT_EN.
module enc_rr_arbiter4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] grant_idx_o,
    output logic       grant_valid_o
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] lastPtr_q, lastPtr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grantIdx_q, grantIdx_d;
    logic       grantValid_q, grantValid_d;

    logic [3:0] otherReq;
    logic       ownerReq;
    logic       anyReq;
    logic       anyOther;
    logic [1:0] winnerAll;
    logic [1:0] winnerOther;

    // Same mapping as the team's 4:2 encoder; zero maps to index 0.
    function automatic logic [1:0] encode4(input logic [3:0] oneHot);
        logic [1:0] idx;
        idx = 2'd0;
        case (oneHot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
    function automatic logic [1:0] rrPick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = ptr + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign otherReq    = req_i & ~grant_q;
    assign ownerReq    = |(req_i & grant_q);
    assign anyReq      = |req_i;
    assign anyOther    = |otherReq;
    assign winnerAll   = rrPick(req_i, lastPtr_q);
    assign winnerOther = rrPick(otherReq, lastPtr_q);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             holdExpired;

    assign holdExpired = (holdCnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d   = state_q;
        lastPtr_d = lastPtr_q;
        grant_d   = grant_q;
        holdCnt_d = holdCnt_q;
        case (state_q)
            IDLE: begin
                holdCnt_d = '0;
                grant_d   = 4'b0000;
                if (en_i && anyReq) begin
                    state_d   = GRANT;
                    lastPtr_d = winnerAll;
                    grant_d   = 4'b0001 << winnerAll;
                end
            end
            GRANT: begin
                if (ownerReq) begin
                    if (holdExpired) begin
                        holdCnt_d = '0;
                        if (en_i && anyOther) begin
                            lastPtr_d = winnerOther;
                            grant_d   = 4'b0001 << winnerOther;
                        end
                    end else if (holdCnt_q != {CNT_W{1'b1}}) begin
                        holdCnt_d = holdCnt_q + 1'b1;
                    end
                end else begin
                    holdCnt_d = '0;
                    if (en_i && anyOther) begin
                        lastPtr_d = winnerOther;
                        grant_d   = 4'b0001 << winnerOther;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            holdCnt_q <= '0;
        end else begin
            holdCnt_q <= holdCnt_d;
        end
    end
`else
    always_comb begin
        state_d   = state_q;
        lastPtr_d = lastPtr_q;
        grant_d   = grant_q;
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (en_i && anyReq) begin
                    state_d   = GRANT;
                    lastPtr_d = winnerAll;
                    grant_d   = 4'b0001 << winnerAll;
                end
            end
            GRANT: begin
                // With en low a release always drops to IDLE rather than handing off.
                if (!ownerReq) begin
                    if (en_i && anyOther) begin
                        lastPtr_d = winnerOther;
                        grant_d   = 4'b0001 << winnerOther;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end
`endif

    assign grantIdx_d   = encode4(grant_d);
    assign grantValid_d = |grant_d;

    // lastPtr resets to 3 so requester 0 is scanned first after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lastPtr_q    <= 2'd3;
            grant_q      <= 4'b0000;
            grantIdx_q   <= 2'd0;
            grantValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastPtr_q    <= lastPtr_d;
            grant_q      <= grant_d;
            grantIdx_q   <= grantIdx_d;
            grantValid_q <= grantValid_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = grantIdx_q;
    assign grant_valid_o = grantValid_q;

`ifndef SYNTHESIS
    grantOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_q));
    grantIdxMatch: assert property (@(posedge clk_i) disable iff (!rst_ni)
        grantIdx_q == encode4(grant_q));
    grantValidMatch: assert property (@(posedge clk_i) disable iff (!rst_ni)
        grantValid_q == (|grant_q));
`endif

endmodule

// File: tb/tb_enc_rr_arbiter4.sv
// Scoreboard bench for enc_rr_arbiter4; the timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_enc_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grantIdx;
    logic       grantValid;

    typedef struct {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    enc_rr_arbiter4 #(
        .HOLD_MAX(4),
        .CNT_W(8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .req_i        (req),
        .grant_o      (grant),
        .grant_idx_o  (grantIdx),
        .grant_valid_o(grantValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(input logic [3:0] g);
        exp_t e;
        e.g = g;
        e.v = (g != 4'b0000);
        case (g)
            4'b0010: e.idx = 2'd1;
            4'b0100: e.idx = 2'd2;
            4'b1000: e.idx = 2'd3;
            default: e.idx = 2'd0;
        endcase
        return e;
    endfunction

    task automatic applyReset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        sbq.push_back(mkExp(4'b0000));
        #2;
        e = sbq.pop_front();
        checks++;
        if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
            errors++;
            $display("[TB] FAIL reset_async: got %b/%0d/%b want %b/%0d/%b",
                     grant, grantIdx, grantValid, e.g, e.idx, e.v);
        end
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(mkExp(4'b0000));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL reset_hold step %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] reqTab[3]   = '{4'b0101, 4'b0100, 4'b0000};
        logic [3:0] grantTab[3] = '{4'b0001, 4'b0100, 4'b0000};
        exp_t e;
        applyReset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = reqTab[i];
            sbq.push_back(mkExp(grantTab[i]));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL basic step %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] reqTab[10]   = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                     4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
        logic [3:0] grantTab[10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                     4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
        exp_t e;
        applyReset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req = reqTab[i];
            sbq.push_back(mkExp(grantTab[i]));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL back_to_back step %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
    endtask

    task automatic test_enable();
        logic       enTab[7]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] reqTab[7]   = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] grantTab[7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        exp_t e;
        applyReset();
        for (int i = 0; i < 7; i++) begin
            en  = enTab[i];
            req = reqTab[i];
            sbq.push_back(mkExp(grantTab[i]));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL enable step %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        applyReset();
        en  = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(mkExp(4'b0100));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL midreset_owner step %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
        #2;
        rst_n = 1'b0;
        sbq.push_back(mkExp(4'b0000));
        #1;
        e = sbq.pop_front();
        checks++;
        if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
            errors++;
            $display("[TB] FAIL midreset_drop: got %b/%0d/%b want %b/%0d/%b",
                     grant, grantIdx, grantValid, e.g, e.idx, e.v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b1111;
        sbq.push_back(mkExp(4'b0001));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
            errors++;
            $display("[TB] FAIL midreset_first: got %b/%0d/%b want %b/%0d/%b",
                     grant, grantIdx, grantValid, e.g, e.idx, e.v);
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        logic [3:0] want;
        applyReset();
        en  = 1'b1;
        req = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            want = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            sbq.push_back(mkExp(want));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL timeout_alt cycle %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
        req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            sbq.push_back(mkExp(4'b0001));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL timeout_solo cycle %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_no_timeout();
        exp_t e;
        applyReset();
        en  = 1'b1;
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            sbq.push_back(mkExp(4'b0001));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
                errors++;
                $display("[TB] FAIL no_timeout cycle %0d: got %b/%0d/%b want %b/%0d/%b",
                         i, grant, grantIdx, grantValid, e.g, e.idx, e.v);
            end
        end
        req = 4'b0010;
        sbq.push_back(mkExp(4'b0010));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if (grant !== e.g || grantIdx !== e.idx || grantValid !== e.v) begin
            errors++;
            $display("[TB] FAIL no_timeout_release: got %b/%0d/%b want %b/%0d/%b",
                     grant, grantIdx, grantValid, e.g, e.idx, e.v);
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_enable();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
